// File: rtl/mltbs_rr_arbtr.sv
// Multi-bus round-robin arbiter: each bus pops one terminal FIFO and pushes the packet to its destination(s).
// Optional macro MLTBS_BCAST_EN enables delivery of broadcast IDs; otherwise they are dropped and counted.
module mltbs_rr_arbtr #(
    parameter int         bits      = 1,
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [bits-1:0][drvrs-1:0]            pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0]            pop,
    output logic [bits-1:0][drvrs-1:0]            push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push,
    output logic [bits-1:0]                       bus_busy,
    output logic [bits-1:0][15:0]                 drop_cnt
);

    localparam int GW = (drvrs > 1) ? $clog2(drvrs) : 1;

    typedef enum logic [1:0] {IDLE, POP, PUSH} state_e;

    for (genvar b = 0; b < bits; b++) begin : g_bus
        state_e             state_q, state_d;
        logic [GW-1:0]      grant_q, grant_d;
        logic [GW-1:0]      last_q, last_d;
        logic [drvrs-1:0]   pop_q, pop_d;
        logic [drvrs-1:0]   push_q, push_d;
        logic [pckg_sz-1:0] pkt_q, pkt_d;
        logic [15:0]        drop_q, drop_d;
        logic               busy_q, busy_d;
        logic               found;
        logic [GW-1:0]      rr_pick;
        logic [GW-1:0]      idx;
        logic [7:0]         dest_id;

        // Scan terminals starting just after the last grant so every requester is served in turn.
        always_comb begin
            found   = 1'b0;
            rr_pick = last_q;
            idx     = last_q;
            for (int k = 1; k <= drvrs; k++) begin
                idx = GW'((int'(last_q) + k) % drvrs);
                if (!found && pndng[b][idx]) begin
                    found   = 1'b1;
                    rr_pick = idx;
                end
            end
        end

        assign dest_id = D_pop[b][grant_q][pckg_sz-1 -: 8];

        always_comb begin
            // NOTE: every output of this block gets a default first, so no path can infer a latch.
            state_d = state_q;
            grant_d = grant_q;
            last_d  = last_q;
            pop_d   = '0;
            push_d  = '0;
            pkt_d   = pkt_q;
            drop_d  = drop_q;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_d        = rr_pick;
                        pop_d[rr_pick] = 1'b1;
                        state_d        = POP;
                    end
                end
                POP: begin
                    pkt_d   = D_pop[b][grant_q];
                    last_d  = grant_q;
                    state_d = PUSH;
                    if (int'(dest_id) < drvrs) begin
                        push_d[dest_id[GW-1:0]] = 1'b1;
                    end
`ifdef MLTBS_BCAST_EN
                    else if (dest_id == broadcast) begin
                        push_d          = '1;
                        push_d[grant_q] = 1'b0;
                    end
`endif
                    else if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
                PUSH: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            busy_d = (state_d != IDLE);
        end

        // NOTE: state flops use non-blocking assignments so every bus samples the same pre-edge values.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                grant_q <= '0;
                last_q  <= GW'(drvrs - 1);
                pop_q   <= '0;
                push_q  <= '0;
                pkt_q   <= '0;
                drop_q  <= '0;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                grant_q <= grant_d;
                last_q  <= last_d;
                pop_q   <= pop_d;
                push_q  <= push_d;
                pkt_q   <= pkt_d;
                drop_q  <= drop_d;
                busy_q  <= busy_d;
            end
        end

        assign pop[b]      = pop_q;
        assign push[b]     = push_q;
        assign bus_busy[b] = busy_q;
        assign drop_cnt[b] = drop_q;
        for (genvar t = 0; t < drvrs; t++) begin : g_term
            assign D_push[b][t] = pkt_q;
        end
    end

endmodule

// File: doc/mltbs_rr_arbtr.md
MLTBS_RR_ARBTR -- requirements
Module: mltbs_rr_arbtr

Interface
REQ-001 Parameter bits, default 1: number of independent buses.
REQ-002 Parameter drvrs, default 4: terminals per bus.
REQ-003 Parameter pckg_sz, default 16: packet width; destination ID is bits [pckg_sz-1:pckg_sz-8].
REQ-004 Parameter broadcast, default 8'hFF: destination ID meaning "all terminals".
REQ-005 clk  input  1: sole clock, rising edge.
REQ-006 reset  input  1: asynchronous, active-low reset.
REQ-007 pndng  input  [bits-1:0][drvrs-1:0]: terminal FIFO non-empty (first-word fall-through).
REQ-008 D_pop  input  [bits-1:0][drvrs-1:0] x pckg_sz: head word of each terminal FIFO.
REQ-009 pop  output  [bits-1:0][drvrs-1:0]: one-cycle pop strobe to a terminal FIFO.
REQ-010 push  output  [bits-1:0][drvrs-1:0]: one-cycle push strobe to a terminal receive FIFO.
REQ-011 D_push  output  [bits-1:0][drvrs-1:0] x pckg_sz: packet driven to receivers; all terminals on a bus carry the same value.
REQ-012 bus_busy  output  [bits-1:0]: bus not in IDLE.
REQ-013 drop_cnt  output  [bits-1:0] x 16: per-bus dropped-packet counter.

Function
REQ-014 Each bus SHALL run its own FSM (IDLE, POP, PUSH), independent of all other buses.
REQ-015 IDLE: if any pndng on the bus, SHALL register grant = first asserted terminal strictly after last_grant (modulo drvrs), then move to POP; otherwise remain in IDLE.
REQ-016 POP: SHALL assert pop for the granted terminal for exactly one cycle, capture D_pop of that terminal, update last_grant, then move to PUSH.
REQ-017 PUSH: SHALL drive D_push with the captured packet and assert push for one cycle per destination rule, then return to IDLE.
REQ-018 Destination rule: ID < drvrs pushes to that terminal only, including ID equal to the source (loopback).
REQ-019 Destination rule: ID == broadcast pushes to every terminal except the source (behaviour of REQ-027).
REQ-020 Destination rule: any other ID asserts no push and increments drop_cnt, saturating at 16'hFFFF.
REQ-021 Throughput SHALL be one packet per 3 cycles per bus; pop SHALL be asserted one cycle after pndng is first sampled in IDLE.
REQ-022 pndng deasserting while in POP or PUSH SHALL NOT abort the transfer in progress.
REQ-023 pop, push and bus_busy SHALL be registered outputs; at most one pop bit per bus SHALL be high in any cycle.

Reset
REQ-024 Assertion of reset, including mid-transfer, SHALL immediately force all FSMs to IDLE, with pop=0, push=0, D_push=0, bus_busy=0 and drop_cnt=0; a captured packet is discarded.
REQ-025 last_grant SHALL reset to drvrs-1, so terminal 0 is granted first.
REQ-026 On deassertion, the first grant decision SHALL occur on the first rising edge at which reset is high.

Configuration
REQ-027 Macro MLTBS_BCAST_EN: when defined, broadcast IDs are delivered per REQ-019; when undefined, the broadcast ID is treated as an invalid destination per REQ-020 (dropped and counted).

Verification
REQ-028 bits=1, drvrs=4: terminal 1 pending with 16'h02AB -> pop[0][1] one cycle later, then push[0][2]=1 with D_push=16'h02AB, no other push bits high.
REQ-029 Terminals 0 and 3 pending continuously, last_grant=0 -> grants alternate 3,0,3,0, with pop pulses 3 cycles apart.
REQ-030 MLTBS_BCAST_EN defined, terminal 2 sends 16'hFF11 -> push bits {0,1,3}=1 and bit 2=0, same cycle; undefined -> no push and drop_cnt=1.
REQ-031 Terminal 0 sends 16'h0755 (ID 7 >= drvrs) -> no push, drop_cnt increments 0->1; with drop_cnt preloaded to 16'hFFFF (forced) -> counter stays at 16'hFFFF.
REQ-032 Reset asserted in the PUSH cycle -> push drops to 0 asynchronously and bus_busy=0; after release, terminal 0 is granted first.
REQ-033 bits=2: bus 0 and bus 1 each pending simultaneously -> both pop in the same cycle, with no cross-bus interaction.
